// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg: shared ROM markers and sequencer state encoding
package ov7670_cfg_pkg;
  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, SEND, ACK, WAIT, DELAY, NEXT, DONE} state_t;
endpackage

// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks the init ROM issuing SCCB writes and timed delays
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int DELAY_MS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_dout,
  input  logic        sccb_ready,
  output logic        sccb_start,
  output logic [7:0]  sccb_addr,
  output logic [7:0]  sccb_data,
  output logic        busy,
  output logic        done
);
  localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int CW = DELAY_CYCLES > 0 ? $clog2(DELAY_CYCLES + 1) : 1;
  state_t        state_q;
  logic [7:0]    rom_addr_q, sccb_addr_q, sccb_data_q;
  logic [CW-1:0] cnt_q;
  logic          sccb_start_q, busy_q, done_q;
  assign rom_addr   = rom_addr_q;
  assign sccb_start = sccb_start_q;
  assign sccb_addr  = sccb_addr_q;
  assign sccb_data  = sccb_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  // Sequencer FSM; sccb_start is raised one cycle early (from DECODE or a waiting SEND)
  // so it is presented only after sccb_ready was seen high, and the idle master cannot drop it meanwhile
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      cnt_q        <= '0;
      sccb_addr_q  <= '0;
      sccb_data_q  <= '0;
      sccb_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sccb_start_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start) begin
          rom_addr_q <= '0;
          done_q     <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= FETCH;
        end
        FETCH: state_q <= DECODE;
        DECODE: if (rom_dout == ROM_END) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end else if (rom_dout == ROM_DELAY) begin
          cnt_q   <= CW'(DELAY_CYCLES);
          state_q <= DELAY;
        end else begin
          sccb_addr_q  <= rom_dout[15:8];
          sccb_data_q  <= rom_dout[7:0];
          sccb_start_q <= sccb_ready;
          state_q      <= SEND;
        end
        SEND: if (sccb_start_q) state_q <= ACK;
              else sccb_start_q <= sccb_ready;
        ACK: state_q <= WAIT;
        WAIT: if (sccb_ready) state_q <= NEXT;
        DELAY: if (cnt_q == '0) state_q <= NEXT;
               else cnt_q <= cnt_q - 1'b1;
        NEXT: if (&rom_addr_q) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end else begin
          rom_addr_q <= rom_addr_q + 8'd1;
          state_q    <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: scoreboard bench with ROM and SCCB master models
module tb_ov7670_config_sequencer;
  localparam int CLK_HZ = 10_000;
  localparam int DMS = 1;
  localparam int DC = CLK_HZ / 1000 * DMS;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] rom_addr, sccb_addr, sccb_data;
  logic [15:0] rom_dout;
  logic sccb_ready, sccb_start, busy, done;
  logic [15:0] rom_mem [256];
  logic m_ready, hold_low = 1'b0, rnd_busy = 1'b0;
  int m_cnt, busy_len = 20;
  int checks = 0, errors = 0, wr_cnt = 0, cyc = 0;
  logic [15:0] exp_q [$];
  logic [15:0] wr_log [$];
  int wr_t [$];
  int addr_t [256];

  always #5 clk = ~clk;

  ov7670_config_sequencer #(.CLK_FREQ_HZ(CLK_HZ), .DELAY_MS(DMS)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .sccb_ready(sccb_ready), .sccb_start(sccb_start), .sccb_addr(sccb_addr),
    .sccb_data(sccb_data), .busy(busy), .done(done)
  );

  // Config ROM: registered read, one cycle latency
  always @(posedge clk) begin
    rom_dout <= rom_mem[rom_addr];
    cyc <= cyc + 1;
  end

  // SCCB master: accepts a write while ready, then stays busy for a programmable time
  assign sccb_ready = m_ready & ~hold_low;
  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_cnt <= 0;
    end else if (sccb_start && sccb_ready) begin
      m_ready <= 1'b0;
      m_cnt <= rnd_busy ? int'($urandom_range(0, 6)) : busy_len;
    end else if (!m_ready) begin
      if (m_cnt == 0) m_ready <= 1'b1;
      else m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write and polices the SCCB handshake
  initial begin
    logic prev_start, in_wr, unstable;
    logic [15:0] held;
    logic [7:0] prev_addr;
    prev_start = 1'b0; in_wr = 1'b0; unstable = 1'b0; held = '0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_wr = 1'b0;
        prev_start = 1'b0;
        unstable = 1'b0;
      end else begin
        if (in_wr && {sccb_addr, sccb_data} !== held) unstable = 1'b1;
        if (in_wr && sccb_ready && !sccb_start) begin
          chk("hold_stable", 32'(unstable), 0);
          in_wr = 1'b0;
        end
        if (sccb_start) begin
          chk("start_while_ready", 32'(sccb_ready), 1);
          chk("start_single_cycle", 32'(prev_start), 0);
          chk("write_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("write_data", 32'({sccb_addr, sccb_data}), 32'(exp_q.pop_front()));
          wr_log.push_back({sccb_addr, sccb_data});
          wr_t.push_back(cyc);
          wr_cnt++;
          held = {sccb_addr, sccb_data};
          in_wr = 1'b1;
          unstable = 1'b0;
        end
        prev_start = sccb_start;
      end
      if (rom_addr != prev_addr) addr_t[rom_addr] = cyc;
      prev_addr = rom_addr;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Reference: every non-marker entry up to the first end marker, at most 256 entries
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      if (rom_mem[i] == 16'hFFFF) break;
      if (rom_mem[i] != 16'hFFF0) exp_q.push_back(rom_mem[i]);
    end
  endtask

  function automatic int end_addr();
    for (int i = 0; i < 256; i++) if (rom_mem[i] == 16'hFFFF) return i;
    return 255;
  endfunction

  task automatic load_real_rom();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'h5A5A;
    rom_mem[0] = 16'h1280;
    rom_mem[1] = 16'hFFF0;
    rom_mem[2] = 16'h1204;
    for (int i = 3; i < 58; i++) rom_mem[i] = {8'(8'h20 + i), 8'(i * 3)};
    rom_mem[58] = 16'h7135;
    rom_mem[59] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    wr_cnt = 0;
    wr_log.delete();
    wr_t.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int k = 0;
    while (!done && k < lim) begin
      tick();
      k++;
    end
    chk({name, "_done"}, 32'(done), 1);
  endtask

  task automatic wait_writes(input int n, input int lim);
    int k = 0;
    while (wr_cnt < n && k < lim) begin
      tick();
      k++;
    end
    chk("reach_write", 32'(wr_cnt >= n), 1);
  endtask

  task automatic tail(input string name, input int n);
    chk({name, "_count"}, 32'(wr_cnt), 32'(n));
    chk({name, "_drained"}, 32'(exp_q.size()), 0);
    chk({name, "_busy_low"}, 32'(busy), 0);
    chk({name, "_end_addr"}, 32'(rom_addr), 32'(end_addr()));
  endtask

  task automatic run_seq(input string name);
    int n;
    build_model();
    n = exp_q.size();
    pulse_start();
    wait_done(name, 40000);
    tail(name, n);
  endtask

  task automatic rst_check(input string name);
    rst = 1'b1;
    tick();
    chk({name, "_rom_addr"}, 32'(rom_addr), 0);
    chk({name, "_sccb_start"}, 32'(sccb_start), 0);
    chk({name, "_sccb_addr"}, 32'(sccb_addr), 0);
    chk({name, "_sccb_data"}, 32'(sccb_data), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  initial begin
    int n, k;
    load_real_rom();
    tick(3);
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_sccb_start", 32'(sccb_start), 0);
    chk("reset_sccb_addr", 32'(sccb_addr), 0);
    chk("reset_sccb_data", 32'(sccb_data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    rst = 1'b0;
    tick();

    build_model();
    n = exp_q.size();
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    chk("start_rom_addr", 32'(rom_addr), 0);
    tick();
    chk("start_n2_idle", 32'(sccb_start), 0);
    tick();
    chk("start_n3_write", 32'(sccb_start), 1);
    wait_writes(5, 5000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("full", 40000);
    tail("full", n);
    chk("full_58", 32'(wr_cnt), 58);
    if (wr_log.size() >= 58) begin
      chk("first_write", 32'(wr_log[0]), 32'h1280);
      chk("second_write", 32'(wr_log[1]), 32'h1204);
      chk("last_write", 32'(wr_log[57]), 32'h7135);
      chk("delay_span", 32'(addr_t[2] - addr_t[1]), 32'(DC + 4));
      chk("no_write_in_delay", 32'(wr_t[0] < addr_t[1] && wr_t[1] > addr_t[2]), 1);
    end

    rnd_busy = 1'b1;
    build_model();
    n = exp_q.size();
    pulse_start();
    chk("restart_done_clear", 32'(done), 0);
    chk("restart_busy", 32'(busy), 1);
    wait_done("restart", 40000);
    tail("restart", n);
    if (wr_log.size() > 0) chk("restart_first", 32'(wr_log[0]), 32'h1280);

    hold_low = 1'b1;
    build_model();
    n = exp_q.size();
    pulse_start();
    k = 0;
    repeat (100) begin
      tick();
      if (sccb_start) k++;
    end
    chk("bp_no_start", 32'(k), 0);
    chk("bp_addr", 32'(sccb_addr), 32'h12);
    chk("bp_data", 32'(sccb_data), 32'h80);
    hold_low = 1'b0;
    tick();
    chk("bp_fire", 32'(sccb_start), 1);
    wait_done("bp", 40000);
    tail("bp", n);

    rnd_busy = 1'b0;
    busy_len = 20;
    build_model();
    pulse_start();
    wait_writes(3, 5000);
    tick(3);
    rst_check("rst_write");
    run_seq("after_rst_write");

    build_model();
    pulse_start();
    k = 0;
    while (rom_addr != 8'd1 && k < 5000) begin
      tick();
      k++;
    end
    tick(4);
    rst_check("rst_delay");
    run_seq("after_rst_delay");

    busy_len = 2;
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'h1234;
    run_seq("no_end");
    tick(5);
    chk("no_end_no_wrap", 32'(rom_addr), 255);
    chk("no_end_done_held", 32'(done), 1);

    rnd_busy = 1'b1;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 256; i++) begin
        logic [15:0] v;
        if ($urandom_range(0, 15) == 0) v = 16'hFFF0;
        else begin
          v = 16'($urandom);
          while (v == 16'hFFFF || v == 16'hFFF0) v = 16'($urandom);
        end
        rom_mem[i] = v;
      end
      rom_mem[$urandom_range(1, 120)] = 16'hFFFF;
      run_seq("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
